alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 60 ++++++
 rtl/alu_issue_ctrl_decode.sv | 69 ++++++
 rtl/alu_issue_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU command codes, MIPS
// opcode/funct encodings, FSM state type and small datapath helpers.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } issue_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

    // Only the arithmetic commands produce meaningful carry/overflow.
    function automatic logic cmd_has_flags(input logic [2:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

    // SLT reports "less than" in the sign bit of the ALU result.
    function automatic logic [31:0] normalise_result(input logic [2:0] cmd,
                                                     input logic [31:0] res);
        logic [31:0] out;
        if (cmd == CMD_SLT) begin
            out = {31'd0, res[31]};
        end else begin
            out = res;
        end
        return out;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational MIPS instruction decode into ALU operands and command.
module alu_instr_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  command,
    output logic        illegal
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [15:0] imm_s;
    logic        unused_fields_s;

    assign opcode_s        = instr[31:26];
    assign funct_s         = instr[5:0];
    assign imm_s           = instr[15:0];
    // Register numbers are resolved upstream; only their values arrive here.
    assign unused_fields_s = ^instr[25:16];

    // Opcode/funct to operand selection and ALU command.
    always_comb begin
        a       = rs_val;
        b       = rt_val;
        command = CMD_ADD;
        illegal = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                b = rt_val;
                case (funct_s)
                    FN_ADD:  command = CMD_ADD;
                    FN_SUB:  command = CMD_SUB;
                    FN_XOR:  command = CMD_XOR;
                    FN_SLT:  command = CMD_SLT;
                    FN_AND:  command = CMD_AND;
                    FN_NOR:  command = CMD_NOR;
                    FN_OR:   command = CMD_OR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                b       = sign_ext16(imm_s);
                command = CMD_ADD;
            end
            OP_SLTI: begin
                b       = sign_ext16(imm_s);
                command = CMD_SLT;
            end
            OP_XORI: begin
                b       = zero_ext16(imm_s);
                command = CMD_XOR;
            end
            OP_ANDI: begin
                b       = zero_ext16(imm_s);
                command = CMD_AND;
            end
            OP_ORI: begin
                b       = zero_ext16(imm_s);
                command = CMD_OR;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues decoded MIPS ALU instructions to an external ALU, waits SETTLE_CYCLES,
// captures the result and returns it. Optional flag capture: ALU_FLAGS_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_illegal,
    output logic        rsp_zero,
    output logic        rsp_carry,
    output logic        rsp_overflow
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [31:0]  dec_a_s;
    logic [31:0]  dec_b_s;
    logic [2:0]   dec_cmd_s;
    logic         dec_illegal_s;
    logic [31:0]  norm_result_s;

    issue_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  alu_a_q, alu_a_d;
    logic [31:0]  alu_b_q, alu_b_d;
    logic [2:0]   alu_cmd_q, alu_cmd_d;
    logic         req_ready_q, req_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_result_q, rsp_result_d;
    logic         rsp_illegal_q, rsp_illegal_d;
    logic         rsp_zero_q, rsp_zero_d;
`ifdef ALU_FLAGS_EN
    logic         rsp_carry_q, rsp_carry_d;
    logic         rsp_ovf_q, rsp_ovf_d;
`else
    logic         unused_flags_s;
`endif

    alu_instr_decode u_decode (
        .instr   (req_instr),
        .rs_val  (req_rs_val),
        .rt_val  (req_rt_val),
        .a       (dec_a_s),
        .b       (dec_b_s),
        .command (dec_cmd_s),
        .illegal (dec_illegal_s)
    );

    assign norm_result_s = normalise_result(alu_cmd_q, alu_result);

    // Next-state and next-output computation for the issue FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cmd_d     = alu_cmd_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_zero_d    = rsp_zero_q;
`ifdef ALU_FLAGS_EN
        rsp_carry_d   = rsp_carry_q;
        rsp_ovf_d     = rsp_ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                rsp_valid_d = 1'b0;
                if (req_valid) begin
                    if (dec_illegal_s) begin
                        // alu_* deliberately left untouched for illegal opcodes.
                        state_d       = ST_DONE;
                        rsp_result_d  = 32'd0;
                        rsp_illegal_d = 1'b1;
                        rsp_zero_d    = 1'b1;
`ifdef ALU_FLAGS_EN
                        rsp_carry_d   = 1'b0;
                        rsp_ovf_d     = 1'b0;
`endif
                    end else begin
                        state_d   = ST_ISSUE;
                        cnt_d     = SETTLE_LOAD;
                        alu_a_d   = dec_a_s;
                        alu_b_d   = dec_b_s;
                        alu_cmd_d = dec_cmd_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 4'd0) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = norm_result_s;
                    rsp_illegal_d = 1'b0;
                    rsp_zero_d    = (norm_result_s == 32'd0);
`ifdef ALU_FLAGS_EN
                    rsp_carry_d   = cmd_has_flags(alu_cmd_q) & alu_carryout;
                    rsp_ovf_d     = cmd_has_flags(alu_cmd_q) & alu_overflow;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // An illegal request enters DONE one cycle before rsp_valid rises.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 4'd0;
                rsp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_cmd_q     <= 3'd0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_illegal_q <= 1'b0;
            rsp_zero_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            rsp_carry_q   <= 1'b0;
            rsp_ovf_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cmd_q     <= alu_cmd_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_zero_q    <= rsp_zero_d;
`ifdef ALU_FLAGS_EN
            rsp_carry_q   <= rsp_carry_d;
            rsp_ovf_q     <= rsp_ovf_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_command = alu_cmd_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_zero    = rsp_zero_q;
`ifdef ALU_FLAGS_EN
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_ovf_q;
`else
    assign unused_flags_s = alu_carryout ^ alu_overflow;
    assign rsp_carry      = 1'b0;
    assign rsp_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instruction vectors, expected
// responses queued at issue and checked by an independent response monitor.
module tb_alu_issue_ctrl;

    localparam int  SETTLE = 2;
    localparam time PERIOD = 10;
`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_illegal;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_overflow;

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_instr    (req_instr),
        .req_rs_val   (req_rs_val),
        .req_rt_val   (req_rt_val),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_illegal  (rsp_illegal),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [31:0] instr, rs, rt, ares;
        logic        ac, aov;
        logic [31:0] ea, eb;
        logic [2:0]  ecmd;
        logic        eill;
        logic [31:0] eres;
        logic        ez, ec, eov;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill, z, c, ov;
        int          lat;
        time         t0;
        string       name;
    } exp_t;

    vec_t  vecs[15];
    exp_t  sb[$];
    exp_t  got;
    int    checks = 0;
    int    errors = 0;
    bit    seen_valid = 1'b0;

    function automatic vec_t mk(logic [31:0] instr, logic [31:0] rs, logic [31:0] rt,
                                logic [31:0] ares, logic ac, logic aov,
                                logic [31:0] ea, logic [31:0] eb, logic [2:0] ecmd,
                                logic eill, logic [31:0] eres, logic ez, logic ec, logic eov);
        vec_t v;
        v.instr = instr; v.rs = rs; v.rt = rt; v.ares = ares; v.ac = ac; v.aov = aov;
        v.ea = ea; v.eb = eb; v.ecmd = ecmd; v.eill = eill; v.eres = eres;
        v.ez = ez; v.ec = ec; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx);
        req_instr    = vecs[idx].instr;
        req_rs_val   = vecs[idx].rs;
        req_rt_val   = vecs[idx].rt;
        alu_result   = vecs[idx].ares;
        alu_carryout = vecs[idx].ac;
        alu_overflow = vecs[idx].aov;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.res  = vecs[idx].eres;
        e.ill  = vecs[idx].eill;
        e.z    = vecs[idx].ez;
        e.c    = FLAGS_ON & vecs[idx].ec;
        e.ov   = FLAGS_ON & vecs[idx].eov;
        e.lat  = vecs[idx].eill ? 1 : SETTLE;
        e.t0   = $time + PERIOD - 1;
        e.name = $sformatf("v%0d", idx);
        sb.push_back(e);
    endtask

    task automatic issue(input int idx);
        int guard = 0;
        load(idx);
        req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            push_exp(idx);
            step();
            req_valid = 1'b0;
            chk($sformatf("v%0d_alu_a", idx), alu_a, vecs[idx].ea);
            chk($sformatf("v%0d_alu_b", idx), alu_b, vecs[idx].eb);
            chk($sformatf("v%0d_alu_cmd", idx), {29'd0, alu_command}, {29'd0, vecs[idx].ecmd});
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            seen_valid = 1'b0;
        end
    endtask

    // Response monitor: latency on first sight of rsp_valid, fields on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else begin
                if (!seen_valid) begin
                    chk({sb[0].name, "_latency"}, 32'(($time - sb[0].t0) / PERIOD), 32'(sb[0].lat));
                    seen_valid = 1'b1;
                end
                if (rsp_ready) begin
                    got = sb.pop_front();
                    seen_valid = 1'b0;
                    chk({got.name, "_result"}, rsp_result, got.res);
                    chk({got.name, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, got.ill});
                    chk({got.name, "_zero"}, {31'd0, rsp_zero}, {31'd0, got.z});
                    chk({got.name, "_carry"}, {31'd0, rsp_carry}, {31'd0, got.c});
                    chk({got.name, "_overflow"}, {31'd0, rsp_overflow}, {31'd0, got.ov});
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_cmd"}, {29'd0, alu_command}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_flags"}, {28'd0, rsp_illegal, rsp_zero, rsp_carry, rsp_overflow}, 32'd0);
    endtask

    initial begin
        //            instr         rs            rt            alu_res       c     ov    exp_a         exp_b         cmd   ill   result        z     c     ov
        vecs[0]  = mk(32'h00430820, 32'd5,        32'd2,        32'd7,        1'b0, 1'b0, 32'd5,        32'd2,        3'd0, 1'b0, 32'd7,        1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(32'h0043082A, 32'hFFFFFFFB, 32'd2,        32'h80000000, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd2,        3'd3, 1'b0, 32'd1,        1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(32'h2041FFFF, 32'd1,        32'h0000DEAD, 32'd0,        1'b1, 1'b0, 32'd1,        32'hFFFFFFFF, 3'd0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(32'h8C410004, 32'h55,       32'h66,       32'h1234,     1'b1, 1'b1, 32'd1,        32'hFFFFFFFF, 3'd0, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(32'h00430822, 32'd10,       32'd3,        32'd7,        1'b1, 1'b0, 32'd10,       32'd3,        3'd1, 1'b0, 32'd7,        1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(32'h00430826, 32'hF0F0,     32'h0FF0,     32'hFF00,     1'b1, 1'b1, 32'hF0F0,     32'h0FF0,     3'd2, 1'b0, 32'hFF00,     1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(32'h00430824, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b1, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 3'd4, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(32'h00430827, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 32'd0,        32'd0,        3'd6, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(32'h00430825, 32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 32'd0,        32'd0,        3'd7, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(32'h28418000, 32'd5,        32'd0,        32'h00008005, 1'b0, 1'b0, 32'd5,        32'hFFFF8000, 3'd3, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0);
        vecs[10] = mk(32'h38418001, 32'h0000FFFF, 32'd0,        32'h00007FFE, 1'b0, 1'b0, 32'h0000FFFF, 32'h00008001, 3'd2, 1'b0, 32'h00007FFE, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(32'h3041FFFF, 32'h12345678, 32'd0,        32'h00005678, 1'b0, 1'b0, 32'h12345678, 32'h0000FFFF, 3'd4, 1'b0, 32'h00005678, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(32'h34411234, 32'd0,        32'd0,        32'h00001234, 1'b0, 1'b0, 32'd0,        32'h00001234, 3'd7, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(32'h00430821, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1, 32'd0,        32'h00001234, 3'd7, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0);
        vecs[14] = mk(32'h00430820, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1,        3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_instr = 32'd0; req_rs_val = 32'd0; req_rt_val = 32'd0;
        alu_result = 32'd0; alu_carryout = 1'b0; alu_overflow = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            issue(i);
            drain();
        end

        // Stall in DONE while a second request waits.
        rsp_ready = 1'b0;
        issue(0);
        for (int g = 0; g < 20 && !rsp_valid; g++) step();
        load(4);
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_result", rsp_result, 32'd7);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_alu_a", alu_a, 32'd5);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        push_exp(4);
        step();
        req_valid = 1'b0;
        chk("second_req_alu_a", alu_a, 32'd10);
        chk("second_req_alu_cmd", {29'd0, alu_command}, 32'd1);
        drain();

        // Reset while the ALU is settling drops the transaction.
        issue(14);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        seen_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
